// File: rtl/fetch_queue2.sv
// rtl/fetch_queue2.sv - two-wide show-ahead instruction queue between fetch and decode
//
// Purpose:
//   Circular queue of DEPTH {data, pc} entries. Each cycle it accepts 0..2
//   entries from IF and exposes the two oldest entries to ID in show-ahead
//   form. ID consumes 0..2 of them each cycle. clr_i flushes in one cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global enable; low freezes all state
//   clr_i                         synchronous flush (same effect as rst)
//   push_cnt_i                    entries offered by IF (0..2, 3 treated as 0)
//   push_data0_i/push_pc0_i       older offered entry
//   push_data1_i/push_pc1_i       younger offered entry
//   push_ready_o                  at least two free slots this cycle
//   pop_cnt_i                     entries consumed by ID (0..2, 3 treated as 2)
//   out_valid_o                   bit0 head valid, bit1 head+1 valid
//   out_data0_o/out_pc0_o         head entry
//   out_data1_o/out_pc1_o         head+1 entry
//   count_o                       current occupancy
//   afull_o                       occupancy >= DEPTH - AFULL_MARGIN

module fetch_queue2 #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr_i,
  input  logic [1:0]                 push_cnt_i,
  input  logic [DATA_W-1:0]          push_data0_i,
  input  logic [PC_W-1:0]            push_pc0_i,
  input  logic [DATA_W-1:0]          push_data1_i,
  input  logic [PC_W-1:0]            push_pc1_i,
  output logic                       push_ready_o,
  input  logic [1:0]                 pop_cnt_i,
  output logic [1:0]                 out_valid_o,
  output logic [DATA_W-1:0]          out_data0_o,
  output logic [PC_W-1:0]            out_pc0_o,
  output logic [DATA_W-1:0]          out_data1_o,
  output logic [PC_W-1:0]            out_pc1_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       afull_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [1:0]        w_push_req;
  logic [1:0]        w_pushn;
  logic [1:0]        w_pop_req;
  logic [1:0]        w_popn;
  logic [AW-1:0]     w_head1;
  logic [AW-1:0]     w_tail1;
  logic              w_advance;

  // Ready depends only on the registered count, so a same-cycle pop never
  // feeds combinationally into push_ready_o.
  assign push_ready_o = (r_count <= CW'(DEPTH - 2));

  // Illegal push count 3 is dropped; illegal pop count 3 acts as 2.
  assign w_push_req = (push_cnt_i == 2'd3) ? 2'd0 : push_cnt_i;
  assign w_pushn    = push_ready_o ? w_push_req : 2'd0;
  assign w_pop_req  = (pop_cnt_i == 2'd3) ? 2'd2 : pop_cnt_i;
  // Over-request is clamped to occupancy; only happens when count <= 1.
  assign w_popn     = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;

  assign w_head1    = r_head + AW'(1);
  assign w_tail1    = r_tail + AW'(1);
  assign w_advance  = !rst && !clr_i && rdy;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      r_head  <= r_head + AW'(w_popn);
      r_tail  <= r_tail + AW'(w_pushn);
      r_count <= r_count + CW'(w_pushn) - CW'(w_popn);
    end
  end

  // Array contents are never reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_advance && (w_pushn != 2'd0)) begin
      r_data[r_tail] <= push_data0_i;
      r_pc[r_tail]   <= push_pc0_i;
      if (w_pushn == 2'd2) begin
        r_data[w_tail1] <= push_data1_i;
        r_pc[w_tail1]   <= push_pc1_i;
      end
    end
  end

  assign out_valid_o[0] = (r_count >= CW'(1));
  assign out_valid_o[1] = (r_count >= CW'(2));
  assign out_data0_o    = r_data[r_head];
  assign out_pc0_o      = r_pc[r_head];
  assign out_data1_o    = r_data[w_head1];
  assign out_pc1_o      = r_pc[w_head1];
  assign count_o        = r_count;
  assign afull_o        = (r_count >= CW'(DEPTH - AFULL_MARGIN));

endmodule

// File: tb/tb_fetch_queue2.sv
// tb/tb_fetch_queue2.sv - scoreboard bench for fetch_queue2

module tb_fetch_queue2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clr_i = 1'b0;
  logic [1:0]  push_cnt_i = 2'd0;
  logic [31:0] push_data0_i = '0;
  logic [31:0] push_pc0_i = '0;
  logic [31:0] push_data1_i = '0;
  logic [31:0] push_pc1_i = '0;
  logic        push_ready_o;
  logic [1:0]  pop_cnt_i = 2'd0;
  logic [1:0]  out_valid_o;
  logic [31:0] out_data0_o;
  logic [31:0] out_pc0_o;
  logic [31:0] out_data1_o;
  logic [31:0] out_pc1_o;
  logic [4:0]  count_o;
  logic        afull_o;

  fetch_queue2 #(.DATA_W(32), .PC_W(32), .DEPTH(16), .AFULL_MARGIN(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
    .push_cnt_i(push_cnt_i),
    .push_data0_i(push_data0_i), .push_pc0_i(push_pc0_i),
    .push_data1_i(push_data1_i), .push_pc1_i(push_pc1_i),
    .push_ready_o(push_ready_o),
    .pop_cnt_i(pop_cnt_i),
    .out_valid_o(out_valid_o),
    .out_data0_o(out_data0_o), .out_pc0_o(out_pc0_o),
    .out_data1_o(out_data1_o), .out_pc1_o(out_pc1_o),
    .count_o(count_o), .afull_o(afull_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic [4:0]  count;
    logic [1:0]  valid;
    logic        ready;
    logic        afull;
    logic        c0;
    logic [31:0] d0;
    logic [31:0] p0;
    logic        c1;
    logic [31:0] d1;
    logic [31:0] p1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h (cycle %0d)", nm, fld, act, req, cyc);
    end
  endtask

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s missed actual=unchecked required=cycle %0d", mon_e.nm, mon_e.cyc);
    end
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk(mon_e.nm, "count", 32'(count_o), 32'(mon_e.count));
      chk(mon_e.nm, "valid", 32'(out_valid_o), 32'(mon_e.valid));
      chk(mon_e.nm, "ready", 32'(push_ready_o), 32'(mon_e.ready));
      chk(mon_e.nm, "afull", 32'(afull_o), 32'(mon_e.afull));
      if (mon_e.c0) begin
        chk(mon_e.nm, "data0", out_data0_o, mon_e.d0);
        chk(mon_e.nm, "pc0", out_pc0_o, mon_e.p0);
      end
      if (mon_e.c1) begin
        chk(mon_e.nm, "data1", out_data1_o, mon_e.d1);
        chk(mon_e.nm, "pc1", out_pc1_o, mon_e.p1);
      end
    end
  end

  task automatic step(input logic [1:0] pn, input logic [31:0] d0, input logic [31:0] p0,
                      input logic [31:0] d1, input logic [31:0] p1, input logic [1:0] popn);
    push_cnt_i = pn;
    push_data0_i = d0; push_pc0_i = p0;
    push_data1_i = d1; push_pc1_i = p1;
    pop_cnt_i = popn;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input int cnt, input logic [1:0] v,
                           input logic rd, input logic af,
                           input logic c0, input logic [31:0] d0, input logic [31:0] p0,
                           input logic c1, input logic [31:0] d1, input logic [31:0] p1);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.count = 5'(cnt); e.valid = v; e.ready = rd; e.afull = af;
    e.c0 = c0; e.d0 = d0; e.p0 = p0; e.c1 = c1; e.d1 = d1; e.p1 = p1;
    sb.push_back(e);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] dh;
    // reset
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    expect_st("reset", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // single push then pop
    step(1, 32'h13, 32'h0, 0, 0, 0);
    expect_st("push1", 1, 2'b01, 1, 0, 1, 32'h13, 32'h0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    expect_st("pop1", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);

    // fill with two per cycle; head/tail start at 1 so the fill wraps
    for (int k = 1; k <= 8; k++) begin
      step(2, 32'h100 + 32'(2*(k-1)), 32'h1000 + 32'(8*(k-1)),
              32'h101 + 32'(2*(k-1)), 32'h1004 + 32'(8*(k-1)), 0);
      expect_st("fill", 2*k, 2'b11, (2*k <= 14), (2*k >= 14),
                1, 32'h100, 32'h1000, 1, 32'h101, 32'h1004);
    end
    step(2, 32'hDEAD, 32'hDEAD, 32'hBEEF, 32'hBEEF, 0);
    expect_st("full_ign", 16, 2'b11, 0, 1, 1, 32'h100, 32'h1000, 1, 32'h101, 32'h1004);
    step(0, 0, 0, 0, 0, 2);
    expect_st("pop2_full", 14, 2'b11, 1, 1, 1, 32'h102, 32'h1008, 1, 32'h103, 32'h100C);
    step(1, 32'h200, 32'h2000, 0, 0, 0);
    expect_st("push_to15", 15, 2'b11, 0, 1, 1, 32'h102, 32'h1008, 0, 0, 0);
    step(2, 32'hDEAD, 32'hDEAD, 32'hBEEF, 32'hBEEF, 0);
    expect_st("ign15", 15, 2'b11, 0, 1, 1, 32'h102, 32'h1008, 0, 0, 0);

    // drain two at a time
    for (int j = 1; j <= 7; j++) begin
      step(0, 0, 0, 0, 0, 2);
      if (j < 7) begin
        dh = 32'h102 + 32'(2*j);
        expect_st("drain", 15 - 2*j, 2'b11, 1, 0, 1, dh, 32'h1000 + 4*(dh - 32'h100), 0, 0, 0);
      end else begin
        expect_st("drain", 1, 2'b01, 1, 0, 1, 32'h200, 32'h2000, 0, 0, 0);
      end
    end
    step(0, 0, 0, 0, 0, 2);
    expect_st("over_pop", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);

    // walk pointers from 2 to 15
    for (int i = 0; i < 13; i++) begin
      step(1, 32'h300 + 32'(i), 32'h3000 + 32'(4*i), 0, 0, 0);
      expect_st("walk_push", 1, 2'b01, 1, 0, 1, 32'h300 + 32'(i), 32'h3000 + 32'(4*i), 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      expect_st("walk_pop", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    end

    // wrap: entry0 at index 15, entry1 at index 0
    step(2, 32'hA0, 32'h100, 32'hA1, 32'h104, 0);
    expect_st("wrap", 2, 2'b11, 1, 0, 1, 32'hA0, 32'h100, 1, 32'hA1, 32'h104);
    step(2, 32'hC0, 32'hC00, 32'hC1, 32'hC04, 0);
    expect_st("to4", 4, 2'b11, 1, 0, 1, 32'hA0, 32'h100, 1, 32'hA1, 32'h104);
    step(2, 32'hC2, 32'hC08, 32'hC3, 32'hC0C, 0);
    expect_st("to6", 6, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);

    // flush wins over same-cycle push and pop
    clr_i = 1'b1;
    step(2, 32'hE0, 32'hE00, 32'hE1, 32'hE04, 1);
    clr_i = 1'b0;
    expect_st("clr", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    expect_st("clr_idle", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h55, 32'h550, 0, 0, 0);
    expect_st("post_clr", 1, 2'b01, 1, 0, 1, 32'h55, 32'h550, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    expect_st("post_clr_pop", 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);

    // freeze with rdy low
    step(2, 32'hB0, 32'hB00, 32'hB1, 32'hB04, 0);
    expect_st("b2", 2, 2'b11, 1, 0, 1, 32'hB0, 32'hB00, 1, 32'hB1, 32'hB04);
    step(2, 32'hB2, 32'hB08, 32'hB3, 32'hB0C, 0);
    expect_st("b4", 4, 2'b11, 1, 0, 1, 32'hB0, 32'hB00, 1, 32'hB1, 32'hB04);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(2, 32'hF0, 32'hF00, 32'hF1, 32'hF04, 2);
      expect_st("freeze", 4, 2'b11, 1, 0, 1, 32'hB0, 32'hB00, 1, 32'hB1, 32'hB04);
    end
    rdy = 1'b1;
    step(0, 0, 0, 0, 0, 2);
    expect_st("thaw_pop", 2, 2'b11, 1, 0, 1, 32'hB2, 32'hB08, 1, 32'hB3, 32'hB0C);

    // let the monitor drain the scoreboard
    n = 0;
    while (sb.size() > 0 && n < 8) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue2.md
# fetch_queue2

Parametrised two-wide instruction queue between the fetch stage (IF) and the decoder (ID). Each cycle it accepts up to two instruction/PC pairs from IF and presents up to two of the oldest entries to ID in show-ahead form, so that ID can consume zero, one or two of them. A single cycle flushes it on branch mispredict. It replaces the single-wide queue and adds generic depth and width, dual push and pop, occupancy count and almost-full reporting.

## Interface
- DATA_W, 32, instruction word width
- PC_W, 32, PC width
- DEPTH, 16, entry count; power of two, at least 4
- AFULL_MARGIN, 2, afull_o asserts when free slots are at or below this value
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- clr_i  in  1  flush; synchronous, same effect as rst
- push_cnt_i  in  2  number of entries offered by IF: 0, 1 or 2 (3 is illegal)
- push_data0_i / push_pc0_i  in  DATA_W / PC_W  older offered entry
- push_data1_i / push_pc1_i  in  DATA_W / PC_W  younger offered entry
- push_ready_o  out  1  at least 2 free slots at the start of the cycle
- pop_cnt_i  in  2  number of entries ID consumes this cycle: 0, 1 or 2 (3 is illegal)
- out_valid_o  out  2  bit0 = head entry valid, bit1 = head+1 entry valid
- out_data0_o / out_pc0_o  out  DATA_W / PC_W  head entry
- out_data1_o / out_pc1_o  out  DATA_W / PC_W  head+1 entry
- count_o  out  $clog2(DEPTH)+1  current occupancy
- afull_o  out  1  count_o >= DEPTH - AFULL_MARGIN

## Operation
- Storage is a circular array of DEPTH entries. Each entry holds a {data, pc} pair.
- The design keeps a head pointer and a tail pointer, each $clog2(DEPTH) bits wide and wrapping naturally modulo DEPTH. It also keeps a separate count register.
- Push:
  - A push is accepted only when push_ready_o=1 and rdy=1.
  - With push_cnt_i=1, entry0 is written at tail. With push_cnt_i=2, entry0 is written at tail and entry1 at tail+1, in that order. tail then advances by push_cnt_i.
  - If push_cnt_i is nonzero while push_ready_o=0, the push is ignored with no state change. IF must hold the offered entries and retry.
- Pop:
  - The effective pop count is popn = min(pop_cnt_i, count). head advances by popn.
  - An over-request is clamped to the occupancy and is not an error.
  - pop_cnt_i=3 is treated as 2 and then clamped.
  - push_cnt_i=3 is treated as 0.
- Count update: count_next = count + pushn - popn, where pushn is the accepted push count.
- Push and pop in the same cycle are independent. push_ready_o is computed from the start-of-cycle count only; an entry popped this cycle is not credited to this cycle's push, so no combinational path runs from pop_cnt_i to push_ready_o.
- Outputs:
  - out_valid_o[0] = (count >= 1) and out_valid_o[1] = (count >= 2).
  - Data and PC outputs are combinational reads of the array at head and head+1 (modulo DEPTH).
  - Data/PC outputs are don't-care whenever the matching valid bit is low.
- Precedence: rst > clr_i > rdy low > normal operation. On clr_i, head, tail and count go to 0 regardless of same-cycle pushes or pops. Array contents are not cleared.

## Timing
- Reset and clear values, visible in the cycle after rst or clr_i is sampled high:
  - count_o=0, out_valid_o=2'b00, push_ready_o=1, afull_o=0.
  - Pointers are 0; array contents are unchanged or undefined.
- Latency: an entry pushed in cycle N appears at the outputs in cycle N+1 at the earliest. There is no same-cycle bypass from push to output.
- Pop effect: a pop in cycle N exposes the next entries in cycle N+1.
- push_ready_o, out_valid_o, count_o and afull_o are functions of registered state only.
- With rdy=0, the pointers, count and array are frozen and the outputs keep their values.
- Wrap-around: writes at tail=DEPTH-1 with push_cnt_i=2 place entry1 at index 0. A head+1 read at head=DEPTH-1 reads index 0.
- Full boundary: push_ready_o=0 whenever count > DEPTH-2, so count can never exceed DEPTH.

## Test plan
- After rst, push 1 entry (data=0x13, pc=0x0), pop 0 -> next cycle out_valid_o=01, out_data0_o=0x13, count_o=1.
- Push 2 per cycle for 8 cycles with DEPTH=16 and no pops -> count_o=16, push_ready_o=0, afull_o=1. Then pop 2 for 1 cycle -> count_o=14 and push_ready_o=1 in the following cycle.
- Fill to count=15 with push_cnt_i=2 offered -> push ignored and count stays 15. Over-request pop_cnt_i=2 at count=1 -> popn=1, count_o=0, out_valid_o=00.
- Wrap test: with head=tail=15, push 2 (pc 0x100, 0x104) -> next cycle out_pc0_o=0x100 (index 15) and out_pc1_o=0x104 (index 0).
- With count=6, assert clr_i together with push_cnt_i=2 and pop_cnt_i=1 -> next cycle count_o=0, out_valid_o=00, and no entries were stored.
- With count=4, hold rdy=0 for 3 cycles while driving pushes and pops -> count_o=4 and the outputs are unchanged throughout.
